// File: rtl/multi_phase_clkgen.sv
// multi_phase_clkgen: NUM_CLOCKS divided clocks from one reference clock.
// Each channel has a staged (shadow) divide ratio and phase offset that are
// copied to the active set atomically on cfg_apply. Outputs are flop-driven
// and held low until the lock counter has run LOCK_CYCLES cycles.
module multi_phase_clkgen #(
    parameter int unsigned NUM_CLOCKS  = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    input  logic                  cfg_apply,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] tick,
    output logic                  locked
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [DIV_W-1:0] sh_div_q  [NUM_CLOCKS];
    logic [DIV_W-1:0] sh_div_d  [NUM_CLOCKS];
    logic [DIV_W-1:0] sh_ph_q   [NUM_CLOCKS];
    logic [DIV_W-1:0] sh_ph_d   [NUM_CLOCKS];
    logic [DIV_W-1:0] act_div_q [NUM_CLOCKS];
    logic [DIV_W-1:0] act_div_d [NUM_CLOCKS];
    logic [DIV_W-1:0] act_ph_q  [NUM_CLOCKS];
    logic [DIV_W-1:0] act_ph_d  [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_q     [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_d     [NUM_CLOCKS];

    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  lock_d;
    logic                  wr_ok;
    logic                  err_d;
    logic [NUM_CLOCKS-1:0] outclk_d, tick_d;

    // Write validation, shadow/active update, counters and next output values.
    always_comb begin
        wr_ok = cfg_we && (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div)
                && (32'(cfg_sel) < NUM_CLOCKS);
        err_d = cfg_we && !wr_ok;

        if (cfg_apply) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q < LOCK_W'(LOCK_CYCLES)) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
        lock_d = (lock_cnt_d == LOCK_W'(LOCK_CYCLES));

        outclk_d = '0;
        tick_d   = '0;
        for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
            sh_div_d[i] = sh_div_q[i];
            sh_ph_d[i]  = sh_ph_q[i];
            // A same-cycle write lands in the shadow before it is applied.
            if (wr_ok && (32'(cfg_sel) == 32'(i))) begin
                sh_div_d[i] = cfg_div;
                sh_ph_d[i]  = cfg_phase;
            end

            if (cfg_apply) begin
                act_div_d[i] = sh_div_d[i];
                act_ph_d[i]  = sh_ph_d[i];
                // Start at (D-P) mod D so the channel lags a P=0 channel by P.
                cnt_d[i] = (sh_ph_d[i] == '0) ? '0 : (sh_div_d[i] - sh_ph_d[i]);
            end else begin
                act_div_d[i] = act_div_q[i];
                act_ph_d[i]  = act_ph_q[i];
                cnt_d[i] = (cnt_q[i] == act_div_q[i] - DIV_W'(1)) ? '0
                                                                   : cnt_q[i] + DIV_W'(1);
            end

            outclk_d[i] = lock_d && (cnt_d[i] < (act_div_d[i] >> 1));
            tick_d[i]   = lock_d && (cnt_d[i] == '0);
        end
    end

    // State and registered outputs; reset also restores the shadow configs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
                sh_div_q[i]  <= DIV_W'(DEFAULT_DIV);
                sh_ph_q[i]   <= '0;
                act_div_q[i] <= DIV_W'(DEFAULT_DIV);
                act_ph_q[i]  <= '0;
                cnt_q[i]     <= '0;
            end
            lock_cnt_q <= '0;
            locked     <= 1'b0;
            outclk     <= '0;
            tick       <= '0;
            cfg_err    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
                sh_div_q[i]  <= sh_div_d[i];
                sh_ph_q[i]   <= sh_ph_d[i];
                act_div_q[i] <= act_div_d[i];
                act_ph_q[i]  <= act_ph_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
            lock_cnt_q <= lock_cnt_d;
            locked     <= lock_d;
            outclk     <= outclk_d;
            tick       <= tick_d;
            cfg_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_multi_phase_clkgen.sv
// Scoreboard bench for multi_phase_clkgen. Three channels are used so that a
// channel index beyond NUM_CLOCKS is expressible on the 2-bit select port.
module tb_multi_phase_clkgen;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int DDIV = 25;
    localparam int LOCK = 16;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [DW-1:0] cfg_phase = '0;
    logic          cfg_apply = 1'b0;
    logic          cfg_err;
    logic [N-1:0]  outclk;
    logic [N-1:0]  tick;
    logic          locked;

    multi_phase_clkgen #(
        .NUM_CLOCKS (N),
        .DIV_W      (DW),
        .DEFAULT_DIV(DDIV),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_apply(cfg_apply),
        .cfg_err  (cfg_err),
        .outclk   (outclk),
        .tick     (tick),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [N-1:0] oc;
        logic [N-1:0] tk;
        logic         lk;
        logic         er;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   done = 0;

    // Reference model: configuration tables plus cycles elapsed since the
    // last reset/apply; each channel's position is pure modular arithmetic.
    int sh_d[N], sh_p[N], ac_d[N], ac_p[N];
    int t = 0;

    task automatic check(input string name, input int got, input int want);
        nchecks++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic step(input bit r, input bit we, input int sel, input int dv,
                        input int ph, input bit ap);
        exp_t e;
        bit   ok;
        rst       = r;
        cfg_we    = we;
        cfg_sel   = 2'(sel);
        cfg_div   = DW'(dv);
        cfg_phase = DW'(ph);
        cfg_apply = ap;

        e = '0;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                sh_d[i] = DDIV; sh_p[i] = 0; ac_d[i] = DDIV; ac_p[i] = 0;
            end
            t = 0;
        end else begin
            ok   = we && dv >= 2 && ph < dv && sel < N;
            e.er = we && !ok;
            if (ok) begin
                sh_d[sel] = dv;
                sh_p[sel] = ph;
            end
            if (ap) begin
                for (int i = 0; i < N; i++) begin
                    ac_d[i] = sh_d[i]; ac_p[i] = sh_p[i];
                end
                t = 0;
            end else begin
                t++;
            end
        end
        e.lk = (t >= LOCK);
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = ((ac_d[i] - ac_p[i]) % ac_d[i] + t) % ac_d[i];
            e.oc[i] = e.lk && (pos < ac_d[i] / 2);
            e.tk[i] = e.lk && (pos == 0);
        end
        exp_q.push_back(e);
        @(posedge refclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a result every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outclk", int'(outclk), int'(e.oc));
                check("tick", int'(tick), int'(e.tk));
                check("locked", int'(locked), int'(e.lk));
                check("cfg_err", int'(cfg_err), int'(e.er));
                cyc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv;
        // Reset and free-run at the default ratio.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(200);
        // Two D=10 channels, one lagging by 5.
        step(0, 1, 1, 10, 0, 0);
        step(0, 1, 2, 10, 5, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(60);
        // Back to defaults, then rejected writes followed by an apply.
        step(1, 0, 0, 0, 0, 0);
        idle(20);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 8, 8, 0);
        step(0, 1, 3, 8, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        idle(60);
        // Write and apply in the same cycle.
        step(0, 1, 0, 4, 0, 1);
        idle(40);
        // Apply at lock count 8, then apply again.
        step(0, 0, 0, 0, 0, 1);
        idle(7);
        step(0, 0, 0, 0, 0, 1);
        idle(30);
        // Reset while ch0 runs D=6.
        step(0, 1, 0, 6, 0, 1);
        idle(30);
        step(1, 1, 0, 9, 0, 1);
        idle(60);
        // Randomized phase.
        for (int k = 0; k < 800; k++) begin
            dv = $urandom_range(0, 12);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), dv, $urandom_range(0, dv + 1),
                 ($urandom_range(0, 29) == 0));
        end
        idle(2);
        // Drain: all expected results must have been consumed.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge refclk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
